matmul_apb_master: RTL and testbench
====================================

Name: matmul_apb_master

Overview:
- APB master bridge that sits directly upstream of the matmul calculator's APB slave port.
- Accepts single register commands from the host/sequencer on a valid/ready command channel and runs each one as a full APB SETUP/ACCESS transfer.
- Returns read data and error status on a valid/ready response channel, and passes the calculator's busy flag through.
- Adds a bounded-wait timeout so that a slave which never asserts pready cannot hang the host.

Parameters:
- DATA_WIDTH, 32, width of pwdata/prdata and of command/response data.
- BUS_WIDTH, 16, width of paddr and cmd_addr_i.
- MAX_WAIT, 255, maximum ACCESS cycles without pready before abort; 0 disables the timeout.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when valid&&ready.
- cmd_write_i  in  1  1=write, 0=read.
- cmd_addr_i  in  BUS_WIDTH  register address.
- cmd_wdata_i  in  DATA_WIDTH  write data.
- cmd_strb_i  in  DATA_WIDTH/8  byte strobes for writes.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when valid&&ready.
- rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_err_o  out  1  pslverr seen, or timeout.
- rsp_timeout_o  out  1  transfer aborted by the timeout.
- psel_o, penable_o, pwrite_o  out  1 each  APB controls.
- paddr_o  out  BUS_WIDTH  APB address.
- pwdata_o  out  DATA_WIDTH  APB write data.
- pstrb_o  out  DATA_WIDTH/8  APB strobes.
- pready_i, pslverr_i  in  1 each  APB slave status.
- prdata_i  in  DATA_WIDTH  APB read data.
- busy_i  in  1  calculator busy.
- busy_o  out  1  registered copy of busy_i, one cycle late.
- idle_o  out  1  FSM in IDLE with no response pending.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: every output and every internal register is 0, and the FSM is in IDLE.
- Reset mid-transfer: psel_o and penable_o drop immediately, and any in-flight command or pending response is discarded with no response issued.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready_o=1 and idle_o=1.
  - On cmd_valid_i, latch write, addr, wdata and strb, then go to SETUP.
  - For reads, latch wdata=0 and strb=0.
- SETUP (exactly 1 cycle):
  - psel_o=1, penable_o=0; paddr_o, pwrite_o, pwdata_o and pstrb_o come from the latched command.
  - Go to ACCESS.
- ACCESS:
  - psel_o=1, penable_o=1; address, data and control are held stable.
  - A wait counter is cleared on entry and increments on each cycle with pready_i=0.
  - If pready_i=1: capture rdata (prdata_i for reads, 0 for writes), set err=pslverr_i and timeout=0, then go to RESP.
  - Else, if MAX_WAIT!=0 and the counter equals MAX_WAIT-1: set rdata=0, err=1, timeout=1, then go to RESP.
  - pready takes priority over the timeout when both occur in the same cycle.
- RESP:
  - psel_o=0, penable_o=0, rsp_valid_o=1.
  - Response fields are held stable until rsp_ready_i.
  - On rsp_ready_i, go to IDLE. rsp_ready_i may be high before or in the same cycle that valid rises.
- Outside SETUP/ACCESS, all APB outputs are driven 0.
- Exactly one command is in flight. Minimum command-to-command period is 4 cycles: IDLE, SETUP, ACCESS and RESP, each 1 cycle with zero waits.
- Latency: with zero wait states, rsp_valid_o rises 3 cycles after the command handshake.
- The wait counter is $clog2(MAX_WAIT+1) bits wide, saturating, and cleared in IDLE.
- cmd_ready_o is 0 in SETUP, ACCESS and RESP. Command inputs are ignored in those states.
- busy_o is a pure registered pass-through and is independent of the FSM.

Test Plan:
- Write, zero-wait: cmd write addr=0x0004, wdata=0xDEADBEEF, strb=0xF; pready tied 1.
  Required: SETUP cycle (psel=1, penable=0), then ACCESS cycle (penable=1) with paddr=0x0004, pwdata=0xDEADBEEF; rsp_valid 3 cycles after accept; rdata=0, err=0.
- Read with 3 wait states: cmd read addr=0x0010; pready=1 on the 4th ACCESS cycle with prdata=0x12345678.
  Required: pstrb=0 and pwdata=0 throughout; rsp_rdata=0x12345678, err=0.
- Slave error: write with pslverr=1 together with pready.
  Required: rsp_err=1, rsp_timeout=0.
- Timeout: MAX_WAIT=8, pready stuck 0.
  Required: exactly 8 ACCESS cycles, then psel=0; rsp_err=1, rsp_timeout=1, rdata=0.
  Also: pready=1 on the 8th cycle gives a normal response.
- Backpressure: hold rsp_ready=0 for 5 cycles, then issue a second command.
  Required: response stable throughout; cmd_ready=0 until the handshake; second command starts only after return to IDLE.
- Async reset: rst_ni=0 mid-ACCESS.
  Required: all outputs 0 immediately with no clock edge; after release, idle_o=1 and no stale response appears.

Source files
------------

// File: rtl/matmul_apb_master.sv
// matmul_apb_master
// Bridges one host register command at a time onto an APB SETUP/ACCESS
// transfer toward the matmul calculator's APB slave port. Read data and
// error status come back on a valid/ready response channel. A bounded wait
// counter aborts transfers whose slave never raises pready.
// Every output is driven directly from a flop, so each output is 0 while
// rst_ni is low and psel/penable drop as soon as reset asserts.

module matmul_apb_master #(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 16,
    parameter int MAX_WAIT   = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    // command channel
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_write_i,
    input  logic [BUS_WIDTH-1:0]    cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb_i,
    // response channel
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    rsp_timeout_o,
    // APB master port
    output logic                    psel_o,
    output logic                    penable_o,
    output logic                    pwrite_o,
    output logic [BUS_WIDTH-1:0]    paddr_o,
    output logic [DATA_WIDTH-1:0]   pwdata_o,
    output logic [DATA_WIDTH/8-1:0] pstrb_o,
    input  logic                    pready_i,
    input  logic                    pslverr_i,
    input  logic [DATA_WIDTH-1:0]   prdata_i,
    // status
    input  logic                    busy_i,
    output logic                    busy_o,
    output logic                    idle_o
);

    localparam int STRB_W = DATA_WIDTH / 8;
    // A zero MAX_WAIT still needs a 1-bit counter so the vector is legal.
    localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        (MAX_WAIT > 0) ? WAIT_W'(MAX_WAIT - 1) : {WAIT_W{1'b0}};
    localparam logic [WAIT_W-1:0] WAIT_SAT = {WAIT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [WAIT_W-1:0]       wait_cnt_r;
    logic                    timeout_hit_s;
    logic                    cmd_fire_s;
    logic                    access_done_s;

    // APB output registers; they also hold the latched command
    logic                    psel_r;
    logic                    penable_r;
    logic                    pwrite_r;
    logic [BUS_WIDTH-1:0]    paddr_r;
    logic [DATA_WIDTH-1:0]   pwdata_r;
    logic [STRB_W-1:0]       pstrb_r;

    // response and status registers
    logic                    rsp_valid_r;
    logic [DATA_WIDTH-1:0]   rsp_rdata_r;
    logic                    rsp_err_r;
    logic                    rsp_timeout_r;
    logic                    cmd_ready_r;
    logic                    idle_r;
    logic                    busy_r;

    // cmd_ready_r is only ever 1 while the FSM sits in IDLE
    assign cmd_fire_s    = cmd_valid_i && cmd_ready_r;
    assign access_done_s = (state_r == ST_ACCESS) && (state_nxt_s == ST_RESP);

    // Timeout fires on the last allowed ACCESS cycle, unless disabled
    always_comb begin
        timeout_hit_s = 1'b0;
        if ((MAX_WAIT != 0) && (wait_cnt_r == WAIT_LAST)) begin
            timeout_hit_s = 1'b1;
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Next-state logic; pready wins over the timeout in the same cycle
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_fire_s) begin
                    state_nxt_s = ST_SETUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_nxt_s = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready_i) begin
                    state_nxt_s = ST_RESP;
                end else if (timeout_hit_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Saturating count of ACCESS cycles without pready; zero outside ACCESS
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if (state_r != ST_ACCESS) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if (!pready_i && (wait_cnt_r != WAIT_SAT)) begin
            wait_cnt_r <= wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Latch the command on accept and hold it on the bus through ACCESS
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            pwrite_r  <= 1'b0;
            paddr_r   <= {BUS_WIDTH{1'b0}};
            pwdata_r  <= {DATA_WIDTH{1'b0}};
            pstrb_r   <= {STRB_W{1'b0}};
        end else if (cmd_fire_s) begin
            psel_r    <= 1'b1;
            penable_r <= 1'b0;
            pwrite_r  <= cmd_write_i;
            paddr_r   <= cmd_addr_i;
            // reads never drive data or strobes onto the bus
            pwdata_r  <= cmd_write_i ? cmd_wdata_i : {DATA_WIDTH{1'b0}};
            pstrb_r   <= cmd_write_i ? cmd_strb_i  : {STRB_W{1'b0}};
        end else if (state_r == ST_SETUP) begin
            penable_r <= 1'b1;
        end else if (access_done_s) begin
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            pwrite_r  <= 1'b0;
            paddr_r   <= {BUS_WIDTH{1'b0}};
            pwdata_r  <= {DATA_WIDTH{1'b0}};
            pstrb_r   <= {STRB_W{1'b0}};
        end else begin
            psel_r    <= psel_r;
            penable_r <= penable_r;
        end
    end

    // Capture the response at the end of ACCESS, clear it on handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else if ((state_r == ST_ACCESS) && pready_i) begin
            rsp_valid_r   <= 1'b1;
            rsp_rdata_r   <= pwrite_r ? {DATA_WIDTH{1'b0}} : prdata_i;
            rsp_err_r     <= pslverr_i;
            rsp_timeout_r <= 1'b0;
        end else if ((state_r == ST_ACCESS) && timeout_hit_s) begin
            rsp_valid_r   <= 1'b1;
            rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
            rsp_err_r     <= 1'b1;
            rsp_timeout_r <= 1'b1;
        end else if ((state_r == ST_RESP) && rsp_ready_i) begin
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else begin
            rsp_valid_r   <= rsp_valid_r;
        end
    end

    // Ready/idle flags track the upcoming state so they are flop outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_ready_r <= 1'b0;
            idle_r      <= 1'b0;
        end else begin
            cmd_ready_r <= (state_nxt_s == ST_IDLE);
            idle_r      <= (state_nxt_s == ST_IDLE);
        end
    end

    // Busy pass-through, one cycle late and independent of the FSM
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= busy_i;
        end
    end

    assign cmd_ready_o   = cmd_ready_r;
    assign idle_o        = idle_r;
    assign busy_o        = busy_r;
    assign psel_o        = psel_r;
    assign penable_o     = penable_r;
    assign pwrite_o      = pwrite_r;
    assign paddr_o       = paddr_r;
    assign pwdata_o      = pwdata_r;
    assign pstrb_o       = pstrb_r;
    assign rsp_valid_o   = rsp_valid_r;
    assign rsp_rdata_o   = rsp_rdata_r;
    assign rsp_err_o     = rsp_err_r;
    assign rsp_timeout_o = rsp_timeout_r;

endmodule

// File: tb/tb_matmul_apb_master.sv
// Directed bench for matmul_apb_master (MAX_WAIT=8). Inputs change and
// outputs are sampled on the falling clock edge.

module tb_matmul_apb_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;
    logic        busy_in;
    logic        busy_out;
    logic        idle;

    int tests_run;
    int tests_failed;

    matmul_apb_master #(
        .DATA_WIDTH (32),
        .BUS_WIDTH  (16),
        .MAX_WAIT   (8)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_write_i   (cmd_write),
        .cmd_addr_i    (cmd_addr),
        .cmd_wdata_i   (cmd_wdata),
        .cmd_strb_i    (cmd_strb),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_err_o     (rsp_err),
        .rsp_timeout_o (rsp_timeout),
        .psel_o        (psel),
        .penable_o     (penable),
        .pwrite_o      (pwrite),
        .paddr_o       (paddr),
        .pwdata_o      (pwdata),
        .pstrb_o       (pstrb),
        .pready_i      (pready),
        .pslverr_i     (pslverr),
        .prdata_i      (prdata),
        .busy_i        (busy_in),
        .busy_o        (busy_out),
        .idle_o        (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Present a command for one cycle; returns at the SETUP-cycle negedge
    task automatic issue(input logic wr, input logic [15:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = s;
        step();
        cmd_valid = 1'b0;
    endtask

    // Bounded wait for rsp_valid
    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (!rsp_valid && n < 40) begin
            step();
            n++;
        end
        check_eq(tag, {63'd0, rsp_valid}, 64'd1);
    endtask

    // Consume the current response and return at the next IDLE negedge
    task automatic take_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cnt;
        tests_run    = 0;
        tests_failed = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 16'h0000;
        cmd_wdata = 32'h0000_0000;
        cmd_strb  = 4'h0;
        rsp_ready = 1'b0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = 32'h0000_0000;
        busy_in   = 1'b0;

        // ---------------- reset state
        step();
        check_eq("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        check_eq("rst_idle",      {63'd0, idle},      64'd0);
        check_eq("rst_psel",      {63'd0, psel},      64'd0);
        check_eq("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check_eq("rst_paddr",     {48'd0, paddr},     64'd0);
        rst_n = 1'b1;
        step();
        check_eq("post_rst_idle",      {63'd0, idle},      64'd1);
        check_eq("post_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);

        // ---------------- busy pass-through is one cycle late
        busy_in = 1'b1;
        #1;
        check_eq("busy_not_yet", {63'd0, busy_out}, 64'd0);
        step();
        check_eq("busy_late", {63'd0, busy_out}, 64'd1);
        busy_in = 1'b0;
        step();
        check_eq("busy_clear", {63'd0, busy_out}, 64'd0);

        // ---------------- write, zero wait states
        pready = 1'b1;
        issue(1'b1, 16'h0004, 32'hDEAD_BEEF, 4'hF);
        check_eq("wr_setup_psel",    {63'd0, psel},      64'd1);
        check_eq("wr_setup_penable", {63'd0, penable},   64'd0);
        check_eq("wr_setup_paddr",   {48'd0, paddr},     64'h0004);
        check_eq("wr_setup_pwrite",  {63'd0, pwrite},    64'd1);
        check_eq("wr_setup_ready",   {63'd0, cmd_ready}, 64'd0);
        step();
        check_eq("wr_acc_penable", {63'd0, penable}, 64'd1);
        check_eq("wr_acc_paddr",   {48'd0, paddr},   64'h0004);
        check_eq("wr_acc_pwdata",  {32'd0, pwdata},  64'hDEAD_BEEF);
        check_eq("wr_acc_pstrb",   {60'd0, pstrb},   64'hF);
        check_eq("wr_acc_no_rsp",  {63'd0, rsp_valid}, 64'd0);
        step();
        check_eq("wr_rsp_valid_lat3", {63'd0, rsp_valid}, 64'd1);
        check_eq("wr_rsp_rdata",      {32'd0, rsp_rdata}, 64'd0);
        check_eq("wr_rsp_err",        {63'd0, rsp_err},   64'd0);
        check_eq("wr_rsp_psel_low",   {63'd0, psel},      64'd0);
        check_eq("wr_rsp_paddr_low",  {48'd0, paddr},     64'd0);
        take_rsp();
        check_eq("wr_back_idle", {63'd0, idle},      64'd1);
        check_eq("wr_rsp_clear", {63'd0, rsp_valid}, 64'd0);

        // ---------------- read with 3 wait states
        pready = 1'b0;
        issue(1'b0, 16'h0010, 32'hFFFF_FFFF, 4'hF);
        check_eq("rd_setup_pstrb",  {60'd0, pstrb},  64'd0);
        check_eq("rd_setup_pwdata", {32'd0, pwdata}, 64'd0);
        check_eq("rd_setup_pwrite", {63'd0, pwrite}, 64'd0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check_eq($sformatf("rd_acc%0d_penable", i), {63'd0, penable}, 64'd1);
            check_eq($sformatf("rd_acc%0d_pstrb", i),   {60'd0, pstrb},   64'd0);
            check_eq($sformatf("rd_acc%0d_paddr", i),   {48'd0, paddr},   64'h0010);
        end
        // fourth ACCESS cycle: slave answers
        pready = 1'b1;
        prdata = 32'h1234_5678;
        step();
        pready = 1'b0;
        prdata = 32'h0000_0000;
        check_eq("rd_rsp_valid",   {63'd0, rsp_valid},   64'd1);
        check_eq("rd_rsp_rdata",   {32'd0, rsp_rdata},   64'h1234_5678);
        check_eq("rd_rsp_err",     {63'd0, rsp_err},     64'd0);
        check_eq("rd_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
        take_rsp();

        // ---------------- slave error on a write
        pready  = 1'b1;
        pslverr = 1'b1;
        issue(1'b1, 16'h0008, 32'h0000_0001, 4'h1);
        wait_rsp("slverr_wait");
        check_eq("slverr_err",     {63'd0, rsp_err},     64'd1);
        check_eq("slverr_timeout", {63'd0, rsp_timeout}, 64'd0);
        pslverr = 1'b0;
        take_rsp();

        // ---------------- timeout with pready stuck low
        pready  = 1'b0;
        prdata  = 32'h5555_AAAA;
        acc_cnt = 0;
        issue(1'b0, 16'h0020, 32'h0000_0000, 4'h0);
        for (int i = 0; i < 30; i++) begin
            if (rsp_valid) break;
            if (psel && penable) acc_cnt++;
            step();
        end
        check_eq("to_access_cycles", 64'(acc_cnt),         64'd8);
        check_eq("to_rsp_valid",     {63'd0, rsp_valid},   64'd1);
        check_eq("to_psel_low",      {63'd0, psel},        64'd0);
        check_eq("to_err",           {63'd0, rsp_err},     64'd1);
        check_eq("to_timeout",       {63'd0, rsp_timeout}, 64'd1);
        check_eq("to_rdata",         {32'd0, rsp_rdata},   64'd0);
        take_rsp();

        // ---------------- pready on the 8th ACCESS cycle beats the timeout
        issue(1'b0, 16'h0024, 32'h0000_0000, 4'h0);
        repeat (7) step();
        step();
        check_eq("late8_penable", {63'd0, penable}, 64'd1);
        pready = 1'b1;
        prdata = 32'hCAFE_F00D;
        step();
        pready = 1'b0;
        check_eq("late8_valid",   {63'd0, rsp_valid},   64'd1);
        check_eq("late8_rdata",   {32'd0, rsp_rdata},   64'hCAFE_F00D);
        check_eq("late8_err",     {63'd0, rsp_err},     64'd0);
        check_eq("late8_timeout", {63'd0, rsp_timeout}, 64'd0);
        take_rsp();

        // ---------------- response backpressure, second command waiting
        pready = 1'b1;
        prdata = 32'h0BAD_C0DE;
        issue(1'b0, 16'h0030, 32'h0000_0000, 4'h0);
        wait_rsp("bp_wait");
        prdata    = 32'h1111_2222;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 16'h0040;
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("bp%0d_valid", i), {63'd0, rsp_valid}, 64'd1);
            check_eq($sformatf("bp%0d_rdata", i), {32'd0, rsp_rdata}, 64'h0BAD_C0DE);
            check_eq($sformatf("bp%0d_ready", i), {63'd0, cmd_ready}, 64'd0);
            check_eq($sformatf("bp%0d_psel", i),  {63'd0, psel},      64'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        check_eq("bp_rsp_gone", {63'd0, rsp_valid}, 64'd0);
        check_eq("bp_ready",    {63'd0, cmd_ready}, 64'd1);
        check_eq("bp_no_psel",  {63'd0, psel},      64'd0);
        step();
        cmd_valid = 1'b0;
        check_eq("bp2_setup_psel",  {63'd0, psel},  64'd1);
        check_eq("bp2_setup_paddr", {48'd0, paddr}, 64'h0040);
        // rsp_ready already high: response lasts exactly one cycle
        step();
        step();
        check_eq("bp2_valid", {63'd0, rsp_valid}, 64'd1);
        check_eq("bp2_rdata", {32'd0, rsp_rdata}, 64'h1111_2222);
        step();
        check_eq("bp2_one_cycle", {63'd0, rsp_valid}, 64'd0);
        rsp_ready = 1'b0;

        // ---------------- asynchronous reset in the middle of ACCESS
        pready = 1'b0;
        issue(1'b1, 16'h0050, 32'h7777_7777, 4'h3);
        step();
        check_eq("ar_in_access", {63'd0, penable}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_psel",      {63'd0, psel},      64'd0);
        check_eq("ar_penable",   {63'd0, penable},   64'd0);
        check_eq("ar_paddr",     {48'd0, paddr},     64'd0);
        check_eq("ar_pwdata",    {32'd0, pwdata},    64'd0);
        check_eq("ar_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        check_eq("ar_idle",      {63'd0, idle},      64'd0);
        step();
        rst_n  = 1'b1;
        pready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq($sformatf("ar_no_stale%0d", i), {63'd0, rsp_valid}, 64'd0);
            check_eq($sformatf("ar_no_psel%0d", i),  {63'd0, psel},      64'd0);
        end
        check_eq("ar_idle_after", {63'd0, idle}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
